rmc_row_streamer: RTL and testbench

- Downstream stage of the row-matrix calculator.
- Captures the packed result row (NUM_ELEM signed accumulators) when the calculator's DONE level rises.
- Requantizes each element: arithmetic right shift with round-half-up, then signed saturation.
- Streams the elements one per beat, element 0 first, over a valid/ready interface to the next layer or output buffer.

---
 rtl/rmc_row_streamer.sv | 131 +++++++++++++
 tb/tb_rmc_row_streamer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmc_row_streamer.sv
// Row streamer: captures the calculator's packed result row on a rising DONE,
// requantizes each element (round-half-up shift + signed saturation) and streams it over valid/ready.
module rmc_row_streamer #(
    parameter int NUM_ELEM  = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic                          CLK,
    input  logic                          n_rst,
    input  logic                          DONE_IN,
    input  logic [NUM_ELEM*IN_WIDTH-1:0]  VEC_IN,
    input  logic                          OUT_READY,
    output logic                          OUT_VALID,
    output logic signed [OUT_WIDTH-1:0]   OUT_DATA,
    output logic [IDX_W-1:0]              OUT_IDX,
    output logic                          OUT_LAST,
    output logic                          BUSY,
    output logic                          OVF
);

    // Handshake: a beat transfers on any rising CLK where OUT_VALID & OUT_READY;
    // while OUT_VALID & ~OUT_READY the beat (DATA/IDX/LAST) is held unchanged.

    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((IN_WIDTH+1)'(1) << RSH) : '0;
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                         r_state;
    logic                           r_done_d;
    logic [NUM_ELEM*IN_WIDTH-1:0]   r_row;
    logic                           r_valid;
    logic signed [OUT_WIDTH-1:0]    r_data;
    logic [IDX_W-1:0]               r_idx;
    logic                           r_last;
    logic                           r_busy;
    logic                           r_ovf;

    logic                           w_cap_req;
    logic                           w_xfer;
    logic [IDX_W-1:0]               w_nxt_idx;
    logic signed [IN_WIDTH-1:0]     w_elem [NUM_ELEM];
    logic signed [IN_WIDTH-1:0]     w_in_elem0;

    // Extra headroom bit keeps the rounding add from wrapping before the shift.
    function automatic logic signed [OUT_WIDTH-1:0] rq(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH:0] ext;
        logic signed [IN_WIDTH:0] s;
        ext = (IN_WIDTH+1)'(x) + RND;
        s   = ext >>> SHIFT;
        if (s > SAT_MAX)      rq = SAT_MAX[OUT_WIDTH-1:0];
        else if (s < SAT_MIN) rq = SAT_MIN[OUT_WIDTH-1:0];
        else                  rq = s[OUT_WIDTH-1:0];
    endfunction

    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
        assign w_elem[k] = r_row[IN_WIDTH*k +: IN_WIDTH];
    end

    assign w_in_elem0 = VEC_IN[IN_WIDTH-1:0];
    assign w_cap_req  = DONE_IN & ~r_done_d;
    assign w_xfer     = r_valid & OUT_READY;
    assign w_nxt_idx  = r_idx + IDX_W'(1);

    always_ff @(posedge CLK) begin
        if (n_rst) begin
            r_state  <= S_IDLE;
            r_done_d <= 1'b1;
            r_row    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done_d <= DONE_IN;
            case (r_state)
                S_IDLE: begin
                    if (w_cap_req) begin
                        r_row   <= VEC_IN;
                        r_data  <= rq(w_in_elem0);
                        r_idx   <= '0;
                        r_last  <= (NUM_ELEM == 1);
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_xfer && !r_last) begin
                        r_data <= rq(w_elem[w_nxt_idx]);
                        r_idx  <= w_nxt_idx;
                        r_last <= (w_nxt_idx == IDX_W'(NUM_ELEM - 1));
                    end else if (w_xfer && r_last) begin
                        if (w_cap_req) begin
                            // Back-to-back row: restart at element 0 with no bubble.
                            r_row  <= VEC_IN;
                            r_data <= rq(w_in_elem0);
                            r_idx  <= '0;
                            r_last <= (NUM_ELEM == 1);
                        end else begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    if (w_cap_req && !(w_xfer && r_last)) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign OUT_VALID = r_valid;
    assign OUT_DATA  = r_data;
    assign OUT_IDX   = r_idx;
    assign OUT_LAST  = r_last;
    assign BUSY      = r_busy;
    assign OVF       = r_ovf;

endmodule

// File: tb/tb_rmc_row_streamer.sv
// Directed bench for rmc_row_streamer: default instance (identity requant) and
// a 16->8 bit instance with SHIFT=2 rounding/saturation.
module tb_rmc_row_streamer;

    logic clk;
    logic rst;

    // Instance A: defaults
    logic              done_a;
    logic [63:0]       vec_a;
    logic              ready_a;
    logic              valid_a;
    logic signed [7:0] data_a;
    logic [2:0]        idx_a;
    logic              last_a;
    logic              busy_a;
    logic              ovf_a;

    // Instance B: IN_WIDTH=16, OUT_WIDTH=8, SHIFT=2
    logic              done_b;
    logic [127:0]      vec_b;
    logic              ready_b;
    logic              valid_b;
    logic signed [7:0] data_b;
    logic [2:0]        idx_b;
    logic              last_b;
    logic              busy_b;
    logic              ovf_b;

    int n_checks;
    int n_errors;
    int exp_idx;
    logic signed [7:0] exp_q[$];

    int row1[8] = '{1, -2, 3, -4, 5, -6, 7, -128};
    int row2[8] = '{10, -20, 30, -40, 50, -60, 70, 127};
    int rowb[8] = '{6, 5, -6, -5, 600, -600, 509, -515};
    int expb[8] = '{2, 1, -1, -1, 127, -128, 127, -128};

    rmc_row_streamer u_dut_a (
        .CLK      (clk),
        .n_rst    (rst),
        .DONE_IN  (done_a),
        .VEC_IN   (vec_a),
        .OUT_READY(ready_a),
        .OUT_VALID(valid_a),
        .OUT_DATA (data_a),
        .OUT_IDX  (idx_a),
        .OUT_LAST (last_a),
        .BUSY     (busy_a),
        .OVF      (ovf_a)
    );

    rmc_row_streamer #(
        .NUM_ELEM (8),
        .IN_WIDTH (16),
        .OUT_WIDTH(8),
        .SHIFT    (2)
    ) u_dut_b (
        .CLK      (clk),
        .n_rst    (rst),
        .DONE_IN  (done_b),
        .VEC_IN   (vec_b),
        .OUT_READY(ready_b),
        .OUT_VALID(valid_b),
        .OUT_DATA (data_b),
        .OUT_IDX  (idx_b),
        .OUT_LAST (last_b),
        .BUSY     (busy_b),
        .OVF      (ovf_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pack8(input int a[8]);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = a[k][7:0];
        return v;
    endfunction

    function automatic logic [127:0] pack16(input int a[8]);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[16*k +: 16] = a[k][15:0];
        return v;
    endfunction

    function automatic logic rdy_pat(input int c);
        case (c % 6)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            3: return 1'b1;
            4: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic fill(input int a[8]);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(a[k]));
    endtask

    // Drives instance A's ready and consumes beats against exp_q; optionally
    // raises DONE (with new_vec) on the cycle beat cap_idx transfers.
    task automatic drain(input int pat, input int cap_idx, input logic [63:0] new_vec, input int budget);
        int cyc;
        logic stalled;
        logic capped;
        logic signed [7:0] p_data;
        logic [2:0] p_idx;
        logic signed [7:0] e;
        cyc = 0;
        stalled = 1'b0;
        capped = 1'b0;
        p_data = '0;
        p_idx = '0;
        exp_idx = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (stalled) begin
                chk("stall_data", data_a, p_data);
                chk("stall_idx", idx_a, p_idx);
            end
            if (pat == 0) chk("no_gap_valid", valid_a, 1);
            ready_a = (pat == 0) ? 1'b1 : rdy_pat(cyc);
            if (valid_a && ready_a) begin
                e = exp_q.pop_front();
                chk("beat_data", data_a, e);
                chk("beat_idx", idx_a, exp_idx);
                chk("beat_last", last_a, (exp_idx == 7) ? 1 : 0);
                chk("beat_busy", busy_a, 1);
                exp_idx = (exp_idx + 1) % 8;
                if (!capped && cap_idx >= 0 && int'(idx_a) == cap_idx) begin
                    done_a = 1'b1;
                    vec_a = new_vec;
                    capped = 1'b1;
                end
            end
            stalled = valid_a && !ready_a;
            p_data = data_a;
            p_idx = idx_a;
            cyc++;
            @(negedge clk);
        end
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int vcount;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        done_a = 1'b0;
        vec_a = '0;
        ready_a = 1'b1;
        done_b = 1'b0;
        vec_b = '0;
        ready_b = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_valid", valid_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic stream, always ready, 1-cycle latency
        vec_a = pack8(row1);
        done_a = 1'b1;
        @(negedge clk);
        chk("first_valid", valid_a, 1);
        vec_a = pack8(row2);
        fill(row1);
        drain(0, -1, '0, 40);
        chk("end_valid", valid_a, 0);
        chk("end_busy", busy_a, 0);
        chk("end_last", last_a, 0);

        // DONE held high: no second capture
        vcount = 0;
        repeat (14) begin
            if (valid_a) vcount++;
            @(negedge clk);
        end
        chk("held_done_beats", vcount, 0);
        chk("held_done_ovf", ovf_a, 0);

        // Back-pressure pattern
        done_a = 1'b0;
        @(negedge clk);
        vec_a = pack8(row2);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        vec_a = '0;
        fill(row2);
        drain(1, -1, '0, 80);
        ready_a = 1'b1;
        chk("bp_end_busy", busy_a, 0);

        // Capture request mid-stream is dropped and flagged
        vec_a = pack8(row1);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        fill(row1);
        drain(0, 3, pack8(row2), 40);
        chk("ovf_set", ovf_a, 1);
        chk("ovf_no_restart", valid_a, 0);

        // Reset mid-stream with DONE high
        done_a = 1'b0;
        @(negedge clk);
        vec_a = pack8(row1);
        done_a = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("pre_rst_idx", idx_a, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_data", data_a, 0);
        chk("mid_rst_idx", idx_a, 0);
        chk("mid_rst_last", last_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ovf", ovf_a, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_cap", valid_a, 0);
        end
        done_a = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy_a, 0);
        done_a = 1'b1;
        @(negedge clk);
        chk("rearm_valid", valid_a, 1);
        fill(row1);
        drain(0, -1, '0, 40);

        // Capture on last-beat transfer: bubble-free second row, no overflow
        done_a = 1'b0;
        @(negedge clk);
        vec_a = pack8(row1);
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        fill(row1);
        fill(row2);
        drain(0, 7, pack8(row2), 60);
        chk("b2b_ovf", ovf_a, 0);
        chk("b2b_end_valid", valid_a, 0);

        // Requantizing instance: SHIFT=2, saturate to 8 bits
        vec_b = pack16(rowb);
        done_b = 1'b1;
        @(negedge clk);
        vec_b = '0;
        for (int k = 0; k < 8; k++) begin
            chk("rq_valid", valid_b, 1);
            chk("rq_data", data_b, expb[k]);
            chk("rq_idx", idx_b, k);
            chk("rq_last", last_b, (k == 7) ? 1 : 0);
            @(negedge clk);
        end
        chk("rq_end_valid", valid_b, 0);
        chk("rq_ovf", ovf_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
